// File: rtl/shift_sequencer.sv
// Multi-cycle register-specified shifter (LSL/LSR/ASR/ROR/RRX), up to STEP bits per cycle.
// Produces operand-2 and shifter carry-out with ARM semantics for amounts of 32 and above.
module shift_sequencer #(
   parameter int DATA_WIDTH = 32,
   parameter int STEP       = 4
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  start,
   input  logic [1:0]            shiftType,
   input  logic [7:0]            amount,
   input  logic                  rrx,
   input  logic [DATA_WIDTH-1:0] rmData,
   input  logic                  carryIn,
   output logic                  busy,
   output logic                  done,
   output logic [DATA_WIDTH-1:0] result,
   output logic                  carryOut
);

   typedef enum logic [1:0] {S_IDLE, S_SHIFT, S_DONE} state_t;

   localparam logic [5:0] STEP_W = 6'(STEP);

   state_t                  state, next_state;
   logic [DATA_WIDTH-1:0]   work;
   logic                    carry_acc;
   logic [5:0]              remaining;
   logic [1:0]              type_q;
   logic                    rrx_q;

   logic [5:0]              eff;
   logic                    carry_init;
   logic [5:0]              n;
   logic [DATA_WIDTH-1:0]   step_work;
   logic                    step_carry;

   // Effective iteration count and starting carry, derived from the live inputs at start.
   always_comb begin
      eff        = '0;
      carry_init = carryIn;
      case (shiftType)
         2'b00, 2'b01: eff = (amount > 8'd33) ? 6'd33 : amount[5:0];
         2'b10:        eff = (amount > 8'd32) ? 6'd32 : amount[5:0];
         default: begin
            if (rrx) begin
               eff = 6'd1;
            end else begin
               eff = {1'b0, amount[4:0]};
               if (amount != 8'd0 && amount[4:0] == 5'd0)
                  carry_init = rmData[DATA_WIDTH-1];
            end
         end
      endcase
   end

   always_comb begin
      n          = (remaining < STEP_W) ? remaining : STEP_W;
      step_work  = work;
      step_carry = carry_acc;
      case (type_q)
         2'b00: begin
            step_work  = work << n;
            step_carry = work[5'(6'd32 - n)];
         end
         2'b01: begin
            step_work  = work >> n;
            step_carry = work[5'(n - 6'd1)];
         end
         2'b10: begin
            step_work  = DATA_WIDTH'($signed(work) >>> n);
            step_carry = work[5'(n - 6'd1)];
         end
         default: begin
            if (rrx_q) begin
               step_work  = {carry_acc, work[DATA_WIDTH-1:1]};
               step_carry = work[0];
            end else begin
               step_work  = (work >> n) | (work << (6'd32 - n));
               step_carry = work[5'(n - 6'd1)];
            end
         end
      endcase
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) state <= S_IDLE;
      else        state <= next_state;
   end

   always_comb begin
      next_state = state;
      case (state)
         S_IDLE:  if (start) next_state = (eff == 6'd0) ? S_DONE : S_SHIFT;
         S_SHIFT: if (remaining <= STEP_W) next_state = S_DONE;
         default: next_state = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         work      <= '0;
         carry_acc <= 1'b0;
         remaining <= '0;
         type_q    <= '0;
         rrx_q     <= 1'b0;
         result    <= '0;
         carryOut  <= 1'b0;
      end else begin
         case (state)
            S_IDLE: begin
               if (start) begin
                  work      <= rmData;
                  carry_acc <= carry_init;
                  remaining <= eff;
                  type_q    <= shiftType;
                  rrx_q     <= rrx;
                  if (eff == 6'd0) begin
                     result   <= rmData;
                     carryOut <= carry_init;
                  end
               end
            end
            S_SHIFT: begin
               work      <= step_work;
               carry_acc <= step_carry;
               remaining <= remaining - n;
               if (remaining <= STEP_W) begin
                  result   <= step_work;
                  carryOut <= step_carry;
               end
            end
            default: ;
         endcase
      end
   end

   assign busy = (state != S_IDLE);
   assign done = (state == S_DONE);

endmodule

// File: tb/tb_shift_sequencer.sv
// Self-checking bench for shift_sequencer: directed cases plus random shifts
// compared against a whole-shift arithmetic reference model.
module tb_shift_sequencer;

   logic        clk = 1'b0;
   logic        reset;
   logic        start;
   logic [1:0]  shiftType;
   logic [7:0]  amount;
   logic        rrx;
   logic [31:0] rmData;
   logic        carryIn;
   logic        busy;
   logic        done;
   logic [31:0] result;
   logic        carryOut;

   int errors = 0;
   int checks = 0;
   logic [31:0] prev_res;
   logic        prev_c;

   always #5 clk = ~clk;

   shift_sequencer #(.DATA_WIDTH(32), .STEP(4)) dut (
      .clk(clk), .reset(reset), .start(start), .shiftType(shiftType),
      .amount(amount), .rrx(rrx), .rmData(rmData), .carryIn(carryIn),
      .busy(busy), .done(done), .result(result), .carryOut(carryOut)
   );

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got=%h expected=%h", tag, got, exp);
      end
   endtask

   // Whole-operation reference: final value, carry and cycle of the done pulse.
   task automatic model(input logic [1:0] t, input logic [7:0] a, input logic r,
                        input logic [31:0] x, input logic cin,
                        output logic [31:0] er, output logic ec, output int lat);
      int eff;
      int s;
      logic signed [31:0] sx;
      sx = x;
      er = x;
      ec = cin;
      eff = 0;
      case (t)
         2'b00: begin
            eff = (a > 33) ? 33 : int'(a);
            if (a == 0) ; else if (a < 32) begin er = x << a; ec = x[32 - a]; end
            else if (a == 32) begin er = 0; ec = x[0]; end
            else begin er = 0; ec = 0; end
         end
         2'b01: begin
            eff = (a > 33) ? 33 : int'(a);
            if (a == 0) ; else if (a < 32) begin er = x >> a; ec = x[a - 1]; end
            else if (a == 32) begin er = 0; ec = x[31]; end
            else begin er = 0; ec = 0; end
         end
         2'b10: begin
            eff = (a > 32) ? 32 : int'(a);
            if (a == 0) ; else if (a < 32) begin er = sx >>> a; ec = x[a - 1]; end
            else begin er = {32{x[31]}}; ec = x[31]; end
         end
         default: begin
            if (r) begin
               eff = 1; er = {cin, x[31:1]}; ec = x[0];
            end else begin
               s = a % 32;
               eff = s;
               if (a == 0) ;
               else if (s == 0) ec = x[31];
               else begin er = (x >> s) | (x << (32 - s)); ec = x[s - 1]; end
            end
         end
      endcase
      lat = (eff + 3) / 4 + 1;
   endtask

   task automatic do_shift(input logic [1:0] t, input logic [7:0] a, input logic r,
                           input logic [31:0] x, input logic cin);
      logic [31:0] er;
      logic        ec;
      int          lat;
      int          dones;
      model(t, a, r, x, cin, er, ec, lat);
      @(negedge clk);
      shiftType = t; amount = a; rrx = r; rmData = x; carryIn = cin; start = 1'b1;
      dones = 0;
      for (int j = 1; j <= lat + 2; j++) begin
         @(negedge clk);
         check("busy", 32'(busy), 32'(j <= lat));
         check("done", 32'(done), 32'(j == lat));
         if (done) dones++;
         if (j < lat) begin
            check("result_hold", result, prev_res);
            check("carry_hold", 32'(carryOut), 32'(prev_c));
         end else begin
            check("result", result, er);
            check("carry", 32'(carryOut), 32'(ec));
         end
         // Garbage on inputs while busy (including the DONE cycle) must be ignored.
         if (j <= lat) begin
            start = 1'($urandom_range(0, 1));
            shiftType = 2'($urandom); amount = 8'($urandom); rrx = 1'($urandom);
            rmData = $urandom; carryIn = 1'($urandom);
         end else begin
            start = 1'b0;
         end
      end
      check("done_count", 32'(dones), 32'd1);
      prev_res = er;
      prev_c   = ec;
   endtask

   logic [7:0] picks [8] = '{8'd0, 8'd1, 8'd31, 8'd32, 8'd33, 8'd64, 8'd200, 8'd255};

   initial begin
      reset = 1'b0; start = 1'b0; shiftType = '0; amount = '0; rrx = 1'b0;
      rmData = '0; carryIn = 1'b0;
      prev_res = '0; prev_c = 1'b0;
      #1;
      check("rst_busy", 32'(busy), 32'd0);
      check("rst_done", 32'(done), 32'd0);
      check("rst_result", result, 32'd0);
      check("rst_carry", 32'(carryOut), 32'd0);
      repeat (2) @(negedge clk);
      reset = 1'b1;

      do_shift(2'b00, 8'd5,   1'b0, 32'h0000_0001, 1'b1);
      do_shift(2'b01, 8'd32,  1'b0, 32'h8000_0000, 1'b0);
      do_shift(2'b00, 8'd40,  1'b0, 32'hFFFF_FFFF, 1'b1);
      do_shift(2'b10, 8'd200, 1'b0, 32'h8000_0000, 1'b0);
      do_shift(2'b10, 8'd31,  1'b0, 32'h4000_0000, 1'b0);
      do_shift(2'b11, 8'd4,   1'b0, 32'h0000_00F1, 1'b1);
      do_shift(2'b11, 8'd32,  1'b0, 32'h8000_0001, 1'b0);
      do_shift(2'b11, 8'd0,   1'b1, 32'h0000_0003, 1'b1);
      do_shift(2'b00, 8'd0,   1'b0, 32'h1234_5678, 1'b1);
      do_shift(2'b01, 8'd33,  1'b0, 32'hFFFF_FFFF, 1'b1);

      for (int i = 0; i < 200; i++) begin
         logic [7:0] a;
         a = ($urandom_range(0, 2) == 0) ? picks[$urandom_range(0, 7)] : 8'($urandom);
         do_shift(2'($urandom), a, ($urandom_range(0, 3) == 0), $urandom, 1'($urandom));
      end

      // Asynchronous abort in the middle of a long shift.
      @(negedge clk);
      shiftType = 2'b01; amount = 8'd32; rrx = 1'b0; rmData = 32'h8000_0000;
      carryIn = 1'b1; start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      repeat (2) @(negedge clk);
      check("mid_busy", 32'(busy), 32'd1);
      #2 reset = 1'b0;
      #1;
      check("abort_busy", 32'(busy), 32'd0);
      check("abort_done", 32'(done), 32'd0);
      check("abort_result", result, 32'd0);
      check("abort_carry", 32'(carryOut), 32'd0);
      @(negedge clk);
      reset = 1'b1;
      prev_res = '0;
      prev_c   = 1'b0;
      for (int j = 0; j < 10; j++) begin
         @(negedge clk);
         check("post_abort_done", 32'(done), 32'd0);
      end
      do_shift(2'b00, 8'd1, 1'b0, 32'h0000_0001, 1'b0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/shift_sequencer.md
Name: shift_sequencer

Overview:
Multi-cycle controller for register-specified shifts, where the shift amount comes from Rs[7:0]. It runs an iterative LSL/LSR/ASR/ROR/RRX over several cycles, shifting at most STEP bits per cycle. It sits beside the single-cycle immediate shifter and produces the operand-2 value and the shifter carry-out with ARM semantics for amounts of 32 and above. The decode/control FSM uses a start/busy/done handshake to stall the pipeline while a shift is in progress.

Parameters:
DATA_WIDTH, 32, operand width (only 32 is supported)
STEP, 4, maximum bits shifted per cycle (1, 2, 4 or 8)

Ports:
clk  input  1  system clock, rising edge
reset  input  1  asynchronous, active-low reset
start  input  1  request a shift; sampled only while busy=0
shiftType  input  2  00 LSL, 01 LSR, 10 ASR, 11 ROR
amount  input  8  shift amount, Rs[7:0]
rrx  input  1  with shiftType=11, performs RRX and ignores amount
rmData  input  32  operand
carryIn  input  1  current CPSR C flag
busy  output  1  high from the cycle after an accepted start through the done cycle
done  output  1  one-cycle pulse; result and carryOut are valid from this cycle
result  output  32  shifted operand; held until the next accepted start
carryOut  output  1  shifter carry-out; held with result

Behaviour:
- Clock and reset: one clock domain, clk. reset is asynchronous and active-low. While reset is low, state=IDLE, busy=0, done=0, result=0, carryOut=0.
- States:
  - IDLE: accepts start.
  - SHIFT: iterating.
  - DONE: one cycle with done=1, then returns to IDLE.
- Start acceptance: start is accepted in IDLE only. On acceptance, capture rmData, shiftType, rrx and carryIn into the work register, compute the effective count eff, and clear the carry accumulator to carryIn.
- Effective count eff:
  - LSL/LSR: min(amount,33). Iterating 32 steps yields 0 with carry equal to the last bit out. Iterating 33 steps yields 0 with carry 0.
  - ASR: min(amount,32). The result is sign fill and the carry is the sign bit.
  - ROR with amount=0: eff=0, result=rmData, carry=carryIn.
  - ROR with amount[4:0]=0 and amount≠0: eff=0, result=rmData, carry=rmData[31].
  - ROR otherwise: eff=amount[4:0].
  - RRX: one step only. result={carryIn,rmData[31:1]}, carry=rmData[0].
  - LSL/LSR/ASR with amount=0: eff=0, result=rmData, carry=carryIn.
- Iteration:
  - Each SHIFT cycle shifts by n=min(remaining,STEP) and decrements remaining by n.
  - Carry becomes the last bit shifted out in that cycle: bit[32-n] for LSL, bit[n-1] for LSR/ASR/ROR.
  - SHIFT leaves when remaining reaches 0.
- Latency: with start accepted at cycle T, k=ceil(eff/STEP) SHIFT cycles occupy T+1..T+k. DONE is at T+k+1. For eff=0, DONE is at T+1 with no SHIFT cycles.
- Output timing: result and carryOut update only on entry to DONE. Between done pulses they hold the previous values.
- Start while busy, including the DONE cycle: ignored and not queued. Inputs may change freely after acceptance.
- Reset mid-operation: immediate abort to the reset values. No done pulse follows.

Test Plan:
- STEP=4, LSL rmData=0x00000001 amount=5 carryIn=1. Required: done at T+3, result=0x00000020, carryOut=0, busy high T+1..T+3.
- LSR rmData=0x80000000 amount=32 → result=0x00000000, carryOut=1, done at T+9. LSL rmData=0xFFFFFFFF amount=40 → result=0, carryOut=0, done at T+10.
- ASR rmData=0x80000000 amount=200 → result=0xFFFFFFFF, carryOut=1. ASR rmData=0x40000000 amount=31 → result=0, carryOut=1.
- ROR rmData=0x000000F1 amount=4 → result=0x1000000F, carryOut=0. ROR amount=32 with rmData=0x80000001 → result unchanged, carryOut=1, done at T+1. RRX with carryIn=1, rmData=0x00000003 → result=0x80000001, carryOut=1.
- amount=0 (LSL), carryIn=1, rmData=0x12345678 → done at T+1, result=0x12345678, carryOut=1. Then a second start is asserted during the busy/DONE cycle of a long shift: it is ignored, the outputs keep the first result, and exactly one done pulse occurs.
- reset driven low during SHIFT of an LSR by 32 → busy, done, result and carryOut go to 0 immediately. After release, a new start of LSL 0x1 by 1 completes normally with result 0x2 at T+2.
